// File: rtl/hazard_pkg.sv
// Shared op-class and forward-select encodings for the ID-stage hazard unit.
// Latency: n/a (constants and pure helpers only).
// Backpressure: n/a.
package hazard_pkg;

    localparam logic [2:0] OPT_NONE  = 3'd0;
    localparam logic [2:0] OPT_ALU   = 3'd1;
    localparam logic [2:0] OPT_LOAD  = 3'd2;
    localparam logic [2:0] OPT_STORE = 3'd3;
    localparam logic [2:0] OPT_MD    = 3'd4;

    localparam logic [2:0] FWD_RF       = 3'd0;
    localparam logic [2:0] FWD_EXE_ALU  = 3'd1;
    localparam logic [2:0] FWD_MEM_ALU  = 3'd2;
    localparam logic [2:0] FWD_MEM_LOAD = 3'd3;
    localparam logic [2:0] FWD_MD       = 3'd4;

    // Op classes that write a destination register through the main pipe or MD port.
    function automatic logic writes_rd(input logic [2:0] opt);
        return (opt == OPT_ALU) || (opt == OPT_LOAD) || (opt == OPT_MD);
    endfunction

endpackage

// File: rtl/md_scoreboard.sv
// One-entry scoreboard for the multi-cycle MUL/DIV unit: countdown plus destination register.
// Latency: issue loads the counter on the next edge; md_wb fires MD_LAT cycles after issue.
// Backpressure: none here; count_gt1 lets the hazard unit hold new MD consumers/producers.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic [REG_AW-1:0] rd_in,
    output logic              count_gt1,
    output logic              md_wb,
    output logic              md_busy,
    output logic [REG_AW-1:0] md_rd
);

    logic [CNT_W-1:0] count;

    // A reload on issue wins over the decrement, which gives back-to-back MD issue at count == 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            md_rd <= '0;
        end else if (issue) begin
            count <= CNT_W'(MD_LAT);
            md_rd <= rd_in;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign count_gt1 = (count > CNT_W'(1));
    assign md_wb     = (count == CNT_W'(1));
    assign md_busy   = (count != '0);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// ID-stage hazard unit with forwarding, load-use and MD scoreboard stalls; LS_FWD_EN adds load-to-store forwarding.
// Latency: all controls combinational from ID inputs and registered op-type/MD state.
// Backpressure: a stall freezes PC and IF/ID and injects a bubble into ID/EXE.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = $clog2(MD_LAT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Branch_ID,
    input  logic              rs1use_ID,
    input  logic              rs2use_ID,
    input  logic [2:0]        hazard_optype_ID,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_ID,
    input  logic [REG_AW-1:0] rd_EXE,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic [REG_AW-1:0] rs2_EXE,
    output logic              PC_EN_IF,
    output logic              reg_FD_EN,
    output logic              reg_FD_stall,
    output logic              reg_FD_flush,
    output logic              reg_DE_EN,
    output logic              reg_DE_flush,
    output logic              reg_EM_EN,
    output logic              reg_EM_flush,
    output logic              reg_MW_EN,
    output logic [2:0]        forward_ctrl_A,
    output logic [2:0]        forward_ctrl_B,
    output logic              forward_ctrl_ls,
    output logic              md_busy,
    output logic              md_wb,
    output logic [REG_AW-1:0] md_rd
);

    logic [2:0] optype_EXE;
    logic [2:0] optype_MEM;
    logic       stall;
    logic       md_issue;
    logic       md_count_gt1;
    logic       src1_match;
    logic       src2_match;
    logic       store_exempt;
    logic       load_use;
    logic       md_raw;
    logic       md_waw;
    logic       md_struct;

    function automatic logic [2:0] fwd_sel(
        input logic              src_match,
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_e,
        input logic [REG_AW-1:0] rd_m,
        input logic [2:0]        opt_e,
        input logic [2:0]        opt_m,
        input logic              wb,
        input logic [REG_AW-1:0] wb_rd
    );
        logic [2:0] sel;
        sel = FWD_RF;
        if (src_match) begin
            if (rs == rd_e && opt_e == OPT_ALU)
                sel = FWD_EXE_ALU;
            else if (rs == rd_m && opt_m == OPT_ALU)
                sel = FWD_MEM_ALU;
            else if (rs == rd_m && opt_m == OPT_LOAD)
                sel = FWD_MEM_LOAD;
            else if (wb && rs == wb_rd)
                sel = FWD_MD;
        end
        return sel;
    endfunction

    assign src1_match = rs1use_ID && (rs1_ID != '0);
    assign src2_match = rs2use_ID && (rs2_ID != '0);

`ifdef LS_FWD_EN
    assign store_exempt    = (hazard_optype_ID == OPT_STORE);
    assign forward_ctrl_ls = (rs2_EXE != '0) && (rs2_EXE == rd_MEM) &&
                             (optype_EXE == OPT_STORE) && (optype_MEM == OPT_LOAD);
`else
    logic ls_unused;
    assign ls_unused       = ^rs2_EXE;
    assign store_exempt    = 1'b0;
    assign forward_ctrl_ls = 1'b0;
`endif

    // MD results are only visible through the dedicated write port, never from EXE/MEM.
    always_comb begin
        forward_ctrl_A = fwd_sel(src1_match, rs1_ID, rd_EXE, rd_MEM, optype_EXE, optype_MEM, md_wb, md_rd);
        forward_ctrl_B = fwd_sel(src2_match, rs2_ID, rd_EXE, rd_MEM, optype_EXE, optype_MEM, md_wb, md_rd);
    end

    always_comb begin
        load_use  = (optype_EXE == OPT_LOAD) &&
                    ((src1_match && rs1_ID == rd_EXE) ||
                     (src2_match && rs2_ID == rd_EXE && !store_exempt));
        md_raw    = md_count_gt1 &&
                    ((src1_match && rs1_ID == md_rd) || (src2_match && rs2_ID == md_rd));
        md_waw    = md_count_gt1 && writes_rd(hazard_optype_ID) &&
                    (rd_ID != '0) && (rd_ID == md_rd);
        md_struct = md_count_gt1 && (hazard_optype_ID == OPT_MD);
        stall     = load_use || md_raw || md_waw || md_struct;
    end

    assign md_issue = (hazard_optype_ID == OPT_MD) && !stall;

    assign PC_EN_IF     = ~stall;
    assign reg_FD_EN    = ~stall;
    assign reg_FD_stall = stall;
    assign reg_FD_flush = Branch_ID;
    assign reg_DE_EN    = 1'b1;
    assign reg_DE_flush = stall;
    assign reg_EM_EN    = 1'b1;
    assign reg_EM_flush = 1'b0;
    assign reg_MW_EN    = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            optype_EXE <= OPT_NONE;
            optype_MEM <= OPT_NONE;
        end else begin
            optype_EXE <= stall ? OPT_NONE : hazard_optype_ID;
            optype_MEM <= optype_EXE;
        end
    end

    md_scoreboard #(
        .REG_AW (REG_AW),
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_md_sb (
        .clk       (clk),
        .rst       (rst),
        .issue     (md_issue),
        .rd_in     (rd_ID),
        .count_gt1 (md_count_gt1),
        .md_wb     (md_wb),
        .md_busy   (md_busy),
        .md_rd     (md_rd)
    );

endmodule

// File: doc/hazard_ctrl_mc.md
# hazard_ctrl_mc

Parametrised successor to the 5-stage pipeline hazard detection unit. Sits in the ID stage and adds a multi-cycle MUL/DIV (MD) functional unit to the existing ALU/LOAD/STORE hazard handling. It tracks in-flight op types through EXE and MEM, keeps a one-entry scoreboard for the MD unit, and drives forwarding selects, stalls and flushes for the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.

## Interface
Parameters:
- REG_AW, 5, register index width.
- MD_LAT, 4, MD unit latency in cycles. Legal range 2..15.
- CNT_W, $clog2(MD_LAT+1), width of the MD countdown counter. Derived; do not override.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- Branch_ID, rs1use_ID, rs2use_ID  in  1 each  branch taken in ID; rs1 used; rs2 used.
- hazard_optype_ID  in  3  op class of the ID instruction: NONE=0, ALU=1, LOAD=2, STORE=3, MD=4.
- rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_MEM, rs2_EXE  in  REG_AW each  register indices.
- PC_EN_IF, reg_FD_EN, reg_FD_stall, reg_FD_flush, reg_DE_EN, reg_DE_flush, reg_EM_EN, reg_EM_flush, reg_MW_EN  out  1 each  pipeline register controls.
- forward_ctrl_A, forward_ctrl_B  out  3 each  operand source: 0 regfile, 1 EXE ALU, 2 MEM ALU, 3 MEM LOAD, 4 MD result.
- forward_ctrl_ls  out  1  route the MEM load data into the store data in EXE.
- md_busy  out  1  MD counter is non-zero.
- md_wb  out  1  MD result valid this cycle; written back on the dedicated port.
- md_rd  out  REG_AW  destination register of the pending MD op.

## Operation
- Op-type pipe: optype_EXE <= stall ? NONE : optype_ID; optype_MEM <= optype_EXE. An MD op enters the pipe as MD, which is never forwarded from EXE or MEM.
- The "src match" condition for rsX, X = 1 or 2: rsXuse_ID && rsX_ID != 0.
- Forward select, highest priority first:
  - 1 if src match, rsX == rd_EXE and optype_EXE == ALU.
  - 2 if src match, rsX == rd_MEM and optype_MEM == ALU.
  - 3 if src match, rsX == rd_MEM and optype_MEM == LOAD.
  - 4 if src match, md_wb and rsX == md_rd.
  - otherwise 0.
- Stall sources (OR of all):
  - Load-use: src match, rsX == rd_EXE and optype_EXE == LOAD. The rs2 case is exempt when optype_ID == STORE, and only under LS_FWD_EN.
  - MD RAW: count > 1 and a src-matched rsX == md_rd.
  - MD WAW: count > 1, optype_ID is ALU, LOAD or MD, and rd_ID == md_rd, with rd_ID != 0.
  - MD structural: count > 1 and optype_ID == MD.
- Pipeline control outputs:
  - PC_EN_IF = reg_FD_EN = ~stall.
  - reg_FD_stall = stall.
  - reg_FD_flush = Branch_ID.
  - reg_DE_flush = stall.
  - reg_DE_EN, reg_EM_EN and reg_MW_EN are 1; reg_EM_flush is 0.
- MD issue: optype_ID == MD && !stall. On issue, count <= MD_LAT and md_rd <= rd_ID. Otherwise, if count != 0, count decrements by 1.
- md_wb = (count == 1). md_busy = (count != 0).
- forward_ctrl_ls = rs2_EXE != 0 && rs2_EXE == rd_MEM && optype_EXE == STORE && optype_MEM == LOAD. It is tied to 0 without LS_FWD_EN.

## Timing
- Reset values:
  - count = 0, md_rd = 0, optype_EXE = optype_MEM = NONE.
  - md_wb = 0, md_busy = 0, forward selects 0, forward_ctrl_ls = 0.
  - Enables are 1 and flushes are 0, unless the ID inputs themselves cause a stall.
- Reset mid-MD clears count on the next edge. No md_wb is produced for the aborted op.
- MD issued in cycle t:
  - md_busy is high for cycles t+1 .. t+MD_LAT.
  - md_wb and the forward-4 window occur in cycle t+MD_LAT.
  - A dependent op in ID stalls for cycles t+1 .. t+MD_LAT-1 and proceeds at t+MD_LAT.
- A new MD op arriving when count == 1 issues in that same cycle (back-to-back). Its count reload takes precedence over the decrement.
- Load-use stall: exactly one bubble.
- Branch_ID together with stall: both reg_FD_flush and reg_FD_stall are asserted. The datapath gives flush priority.
- All outputs except the registered state are combinational from inputs and state. No output is registered.

## Configuration
- LS_FWD_EN defined:
  - Load-to-store rs2 hazards are resolved by forward_ctrl_ls.
  - The rs2 load-use stall is suppressed when the ID instruction is a STORE.
- LS_FWD_EN undefined:
  - forward_ctrl_ls = 0.
  - A STORE whose rs2 is a load-use hazard stalls one cycle, like any other consumer.

## Structure
- Package hazard_pkg holds:
  - optype constants OPT_NONE, OPT_ALU, OPT_LOAD, OPT_STORE, OPT_MD.
  - forward select constants FWD_RF, FWD_EXE_ALU, FWD_MEM_ALU, FWD_MEM_LOAD, FWD_MD.
- One sub-module, md_scoreboard:
  - Contains the countdown counter and the md_rd register.
  - Inputs clk, rst, issue, rd_in.
  - Outputs count_gt1, md_wb, md_busy, md_rd.

## Test plan
- Reset mid-MD: issue MD to x7, assert rst at count = 2 → count = 0 next cycle; no md_wb pulse ever appears.
- Forward priority: ADD x5 in EXE and ADD x5 in MEM; ID reads rs1 = x5 → forward_ctrl_A = 1, no stall.
- Load-use: LW x6 in EXE; ID is ADD using rs2 = x6 → one cycle with PC_EN_IF = 0 and reg_DE_flush = 1; next cycle forward_ctrl_B = 3.
- MD RAW, MD_LAT = 4: MUL x9 issues at t; ADD reads x9 → stall for t+1..t+3; at t+4 md_wb = 1, forward_ctrl_A = 4, no stall.
- MD structural and back-to-back: DIV follows MUL in ID at t+1 → stalls until t+4, issues at t+4 (count = 1); md_wb at t+4 and again at t+8.
- Store after load: LW x3 in MEM, SW rs2 = x3 in EXE → forward_ctrl_ls = 1 with LS_FWD_EN. Without it, the store stalls one cycle in ID and forward_ctrl_ls stays 0.
